// File: rtl/merlin_mem_arbiter_if.sv
// rtl/merlin_mem_arbiter_if.sv - instruction, data and memory request/response bundle for merlin_mem_arbiter
interface merlin_mem_arbiter_if;
  logic        ireqready_o;
  logic        ireqvalid_i;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        irspready_i;
  logic        irspvalid_o;
  logic        irsprerr_o;
  logic [31:0] irspdata_o;

  logic        dreqready_o;
  logic        dreqvalid_i;
  logic [1:0]  dreqsize_i;
  logic        dreqwrite_i;
  logic [1:0]  dreqhpl_i;
  logic [31:0] dreqaddr_i;
  logic [31:0] dreqdata_i;
  logic        drspready_i;
  logic        drspvalid_o;
  logic        drsprerr_o;
  logic        drspwerr_o;
  logic [31:0] drspdata_o;

  logic        mreqready_i;
  logic        mreqvalid_o;
  logic [1:0]  mreqsize_o;
  logic        mreqwrite_o;
  logic [1:0]  mreqhpl_o;
  logic [31:0] mreqaddr_o;
  logic [31:0] mreqdata_o;
  logic        mrspready_o;
  logic        mrspvalid_i;
  logic        mrsperr_i;
  logic [31:0] mrspdata_i;

  // slave: the arbiter itself; master: the core and memory around it
  modport slave (
    output ireqready_o, input ireqvalid_i, input ireqhpl_i, input ireqaddr_i,
    input irspready_i, output irspvalid_o, output irsprerr_o, output irspdata_o,
    output dreqready_o, input dreqvalid_i, input dreqsize_i, input dreqwrite_i,
    input dreqhpl_i, input dreqaddr_i, input dreqdata_i,
    input drspready_i, output drspvalid_o, output drsprerr_o, output drspwerr_o, output drspdata_o,
    input mreqready_i, output mreqvalid_o, output mreqsize_o, output mreqwrite_o,
    output mreqhpl_o, output mreqaddr_o, output mreqdata_o,
    output mrspready_o, input mrspvalid_i, input mrsperr_i, input mrspdata_i
  );

  modport master (
    input ireqready_o, output ireqvalid_i, output ireqhpl_i, output ireqaddr_i,
    output irspready_i, input irspvalid_o, input irsprerr_o, input irspdata_o,
    input dreqready_o, output dreqvalid_i, output dreqsize_i, output dreqwrite_i,
    output dreqhpl_i, output dreqaddr_i, output dreqdata_i,
    output drspready_i, input drspvalid_o, input drsprerr_o, input drspwerr_o, input drspdata_o,
    output mreqready_i, input mreqvalid_o, input mreqsize_o, input mreqwrite_o,
    input mreqhpl_o, input mreqaddr_o, input mreqdata_o,
    input mrspready_o, output mrspvalid_i, output mrsperr_i, output mrspdata_i
  );
endinterface

// File: rtl/merlin_mem_arbiter.sv
// rtl/merlin_mem_arbiter.sv - 2:1 instruction/data arbiter onto one memory port with in-order response routing
// MERLIN_ARB_RR_EN selects round-robin arbitration; undefined gives fixed data-over-instruction priority.
module merlin_mem_arbiter #(
  parameter int C_OUTSTANDING_X = 2
) (
  input  logic                 clk_i,
  input  logic                 resetb_i,
  input  logic                 clk_en_i,
  merlin_mem_arbiter_if.slave  bus
);
  localparam int DEPTH = 1 << C_OUTSTANDING_X;
  localparam logic [C_OUTSTANDING_X:0]   L_FULL    = DEPTH;
  localparam logic [C_OUTSTANDING_X:0]   L_CNT_ONE = 1;
  localparam logic [C_OUTSTANDING_X-1:0] L_PTR_ONE = 1;

  logic        r_mreq_valid;
  logic [1:0]  r_mreq_size;
  logic        r_mreq_write;
  logic [1:0]  r_mreq_hpl;
  logic [31:0] r_mreq_addr;
  logic [31:0] r_mreq_data;

  logic [C_OUTSTANDING_X:0]   r_count;
  logic [C_OUTSTANDING_X-1:0] r_rd_ptr;
  logic [C_OUTSTANDING_X-1:0] r_wr_ptr;
  logic [DEPTH-1:0]           r_fifo_src;
  logic [DEPTH-1:0]           r_fifo_wr;

  logic w_loadable;
  logic w_full;
  logic w_empty;
  logic w_grant_i;
  logic w_grant_d;
  logic w_ireq_ready;
  logic w_dreq_ready;
  logic w_push;
  logic w_pop;
  logic w_head_src;
  logic w_head_wr;
  logic w_mrsp_ready;

  assign w_loadable = clk_en_i & (~r_mreq_valid | bus.mreqready_i);
  assign w_full     = (r_count == L_FULL);
  assign w_empty    = (r_count == '0);

`ifdef MERLIN_ARB_RR_EN
  // r_last_d=1 means data won last; reset value lets data win the first tie
  logic r_last_d;
  assign w_grant_d = bus.dreqvalid_i & (~bus.ireqvalid_i | ~r_last_d);

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_last_d <= 1'b0;
    end else if (w_push) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = bus.dreqvalid_i;
`endif

  assign w_grant_i    = bus.ireqvalid_i & ~w_grant_d;
  assign w_ireq_ready = resetb_i & w_loadable & ~w_full & w_grant_i;
  assign w_dreq_ready = resetb_i & w_loadable & ~w_full & w_grant_d;
  assign w_push       = w_ireq_ready | w_dreq_ready;
  assign w_pop        = bus.mrspvalid_i & w_mrsp_ready;

  assign bus.ireqready_o = w_ireq_ready;
  assign bus.dreqready_o = w_dreq_ready;
  assign bus.mreqvalid_o = r_mreq_valid;
  assign bus.mreqsize_o  = r_mreq_size;
  assign bus.mreqwrite_o = r_mreq_write;
  assign bus.mreqhpl_o   = r_mreq_hpl;
  assign bus.mreqaddr_o  = r_mreq_addr;
  assign bus.mreqdata_o  = r_mreq_data;
  assign bus.mrspready_o = w_mrsp_ready;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_mreq_valid <= 1'b0;
      r_mreq_size  <= 2'b00;
      r_mreq_write <= 1'b0;
      r_mreq_hpl   <= 2'b00;
      r_mreq_addr  <= 32'h0;
      r_mreq_data  <= 32'h0;
    end else if (w_push) begin
      r_mreq_valid <= 1'b1;
      if (w_grant_d) begin
        r_mreq_size  <= bus.dreqsize_i;
        r_mreq_write <= bus.dreqwrite_i;
        r_mreq_hpl   <= bus.dreqhpl_i;
        r_mreq_addr  <= bus.dreqaddr_i;
        r_mreq_data  <= bus.dreqdata_i;
      end else begin
        r_mreq_size  <= 2'b10;
        r_mreq_write <= 1'b0;
        r_mreq_hpl   <= bus.ireqhpl_i;
        r_mreq_addr  <= bus.ireqaddr_i;
        r_mreq_data  <= 32'h0;
      end
    end else if (clk_en_i & bus.mreqready_i) begin
      r_mreq_valid <= 1'b0;
    end
  end

  // Ordering FIFO: one {src, write} tag per in-flight request
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fifo_src <= '0;
      r_fifo_wr  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_src[r_wr_ptr] <= w_grant_d;
        r_fifo_wr[r_wr_ptr]  <= w_grant_d & bus.dreqwrite_i;
        r_wr_ptr             <= r_wr_ptr + L_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head_src = r_fifo_src[r_rd_ptr];
  assign w_head_wr  = r_fifo_wr[r_rd_ptr];

  // An empty FIFO leaves every response path closed, stalling stray responses
  always_comb begin
    bus.irspvalid_o = 1'b0;
    bus.irsprerr_o  = 1'b0;
    bus.irspdata_o  = 32'h0;
    bus.drspvalid_o = 1'b0;
    bus.drsprerr_o  = 1'b0;
    bus.drspwerr_o  = 1'b0;
    bus.drspdata_o  = 32'h0;
    w_mrsp_ready    = 1'b0;
    if (!w_empty) begin
      if (w_head_src) begin
        bus.drspvalid_o = bus.mrspvalid_i;
        bus.drspdata_o  = bus.mrspdata_i;
        bus.drspwerr_o  = bus.mrsperr_i & w_head_wr;
        bus.drsprerr_o  = bus.mrsperr_i & ~w_head_wr;
        w_mrsp_ready    = bus.drspready_i & clk_en_i;
      end else begin
        bus.irspvalid_o = bus.mrspvalid_i;
        bus.irsprerr_o  = bus.mrsperr_i;
        bus.irspdata_o  = bus.mrspdata_i;
        w_mrsp_ready    = bus.irspready_i & clk_en_i;
      end
    end
  end
endmodule

// File: doc/merlin_mem_arbiter.md
# merlin_mem_arbiter

Two-to-one memory arbiter downstream of the merlin32i core. It merges the core's instruction port (ireq/irsp) and data port (dreq/drsp) onto one shared memory port (mreq/mrsp). Requests go out through a registered request slot. Responses return in order and are routed back to their originating port by an ordering FIFO.

## Interface
- C_OUTSTANDING_X, 2: base-2 exponent of the ordering FIFO depth; max in-flight requests = 2^C_OUTSTANDING_X.
- clk_i  in  1  clock; one clock domain, all logic on its rising edge.
- resetb_i  in  1  reset; asynchronous, active-low.
- clk_en_i  in  1  clock enable; no state changes and no handshakes complete while low.
- ireqready_o  out  1  instruction request accepted.
- ireqvalid_i  in  1  instruction request valid.
- ireqhpl_i  in  2  instruction request privilege level.
- ireqaddr_i  in  32  instruction fetch address.
- irspready_i  in  1  core can take an instruction response.
- irspvalid_o  out  1  instruction response valid.
- irsprerr_o  out  1  instruction read error.
- irspdata_o  out  32  instruction response data.
- dreqready_o  out  1  data request accepted.
- dreqvalid_i  in  1  data request valid.
- dreqsize_i  in  2  data access size.
- dreqwrite_i  in  1  data request is a write.
- dreqhpl_i  in  2  data request privilege level.
- dreqaddr_i  in  32  data address.
- dreqdata_i  in  32  write data.
- drspready_i  in  1  core can take a data response.
- drspvalid_o  out  1  data response valid.
- drsprerr_o  out  1  data read error.
- drspwerr_o  out  1  data write error.
- drspdata_o  out  32  data response data.
- mreqready_i  in  1  memory accepts the request.
- mreqvalid_o  out  1  request valid.
- mreqsize_o  out  2  access size.
- mreqwrite_o  out  1  request is a write.
- mreqhpl_o  out  2  privilege level.
- mreqaddr_o  out  32  address.
- mreqdata_o  out  32  write data.
- mrspready_o  out  1  arbiter accepts the response.
- mrspvalid_i  in  1  response valid.
- mrsperr_i  in  1  response error.
- mrspdata_i  in  32  response data.

## Operation
- Request slot: mreq* outputs are registered.
- The slot is "loadable" when clk_en_i=1, and either mreqvalid_o=0 or mreqready_i=1.
- FIFO state: count register, C_OUTSTANDING_X+1 bits; "full" means count = 2^C_OUTSTANDING_X.
- Grant is combinational among ireqvalid_i and dreqvalid_i.
- ireqready_o = loadable & !full & grant_i. dreqready_o = loadable & !full & grant_d. At most one ready is high per cycle.
- On acceptance:
  - The slot loads the granted request and mreqvalid_o goes to 1.
  - The FIFO pushes {src, write}, where src is 0 = instruction, 1 = data.
- Instruction request field mapping: mreqsize_o=2'b10, mreqwrite_o=0, mreqdata_o=0.
- If the slot drains (mreqready_i=1) with no new acceptance, mreqvalid_o goes to 0. The other mreq* fields hold their last value.
- Response routing: the FIFO head selects the port.
  - Head src=0: irspvalid_o=mrspvalid_i, irsprerr_o=mrsperr_i, irspdata_o=mrspdata_i, mrspready_o=irspready_i & clk_en_i.
  - Head src=1: drspvalid_o=mrspvalid_i, drspdata_o=mrspdata_i, mrspready_o=drspready_i & clk_en_i. The error goes to drspwerr_o if head write=1, else to drsprerr_o.
  - The non-selected port has valid=0, errors=0, data=0.
- FIFO pop on mrspvalid_i & mrspready_o.
- FIFO empty: all rsp valids=0 and mrspready_o=0, so a stray response is stalled and never delivered.
- Full plus pop in the same cycle: push is still blocked that cycle, because full is evaluated on the registered count.
- Push and pop in the same cycle when not full: count is unchanged.

## Timing
- Request latency: accepted in cycle N, mreqvalid_o=1 in cycle N+1. Back-to-back acceptance gives one request per cycle while mreqready_i=1.
- Response path is fully combinational, mrsp to irsp/drsp, zero latency.
- Reset (asynchronous, any time, including mid-transaction):
  - mreqvalid_o=0, mreqsize_o/mreqwrite_o/mreqhpl_o/mreqaddr_o/mreqdata_o=0.
  - FIFO count, read pointer and write pointer = 0; the round-robin pointer selects data first.
  - All readies and response valids are 0 while resetb_i=0.
  - In-flight responses after reset are stalled because the FIFO is empty.
- Once mreqvalid_o=1, its fields are stable until mreqready_i=1.

## Configuration
- MERLIN_ARB_RR_EN defined:
  - Round-robin arbitration. A 1-bit last-granted register updates on each acceptance.
  - When both ports are valid, the one not granted last wins; a single valid requester always wins.
- MERLIN_ARB_RR_EN undefined: fixed priority, data beats instruction; no pointer register.

## Test plan
- Single fetch, addr 0x100:
  - mreqvalid_o=1 the next cycle with addr 0x100, size 2'b10, write 0.
  - Response data 0xDEADBEEF appears on irspdata_o with irspvalid_o=1 and drspvalid_o=0.
- Fixed priority, ireqvalid_i and dreqvalid_i both high for 2 cycles: dreqready_o=1 both cycles and ireqready_o=0. With MERLIN_ARB_RR_EN defined, grants alternate D, I.
- Data write 0x40 with mrsperr_i=1 on its response: drspwerr_o=1, drsprerr_o=0, FIFO pops.
- Default depth 4, mreqready_i=1, no responses:
  - After 4 acceptances both readies stay 0.
  - One response pop lets a fifth acceptance happen the following cycle.
- Back-pressure, mreqready_i=0 with mreqvalid_o=1: mreq* fields hold and both upstream readies are 0.
- resetb_i pulsed low with 2 outstanding: mreqvalid_o=0 immediately; a following mrspvalid_i=1 sees mrspready_o=0 and no upstream valid.
